decode_control_unit: RTL

DECODE_CONTROL_UNIT -- requirements
Module: decode_control_unit

---
 rtl/decode_control_unit.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/decode_control_unit.sv
// rtl/decode_control_unit.sv - ID-stage decode, load-use hazard detection and ID/EX control register
module decode_control_unit #(
  parameter int BUBBLE_CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             id_instruction,
  input  logic                    id_valid,
  input  logic                    mem_stall,
  input  logic                    ex_flush,
  output logic [2:0]              imm_src,
  output logic                    stall_if,
  output logic                    stall_id,
  output logic                    ex_valid,
  output logic                    ex_reg_write,
  output logic                    ex_mem_read,
  output logic                    ex_mem_write,
  output logic                    ex_branch,
  output logic                    ex_jump,
  output logic                    ex_alu_src,
  output logic                    ex_illegal,
  output logic [1:0]              ex_result_src,
  output logic [4:0]              ex_rd,
  output logic [4:0]              ex_rs1,
  output logic [4:0]              ex_rs2,
  output logic [2:0]              ex_funct3,
  output logic [BUBBLE_CNT_W-1:0] bubble_count
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic       illegal;
    logic [1:0] result_src;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
  } ex_ctrl_t;

  ex_ctrl_t                dec_ctrl;
  ex_ctrl_t                ex_d;
  ex_ctrl_t                ex_q;
  logic [BUBBLE_CNT_W-1:0] bubble_cnt_d;
  logic [BUBBLE_CNT_W-1:0] bubble_cnt_q;
  logic                    use_rs1;
  logic                    use_rs2;
  logic                    rs1_hit;
  logic                    rs2_hit;
  logic                    load_use;
  logic [6:0]              opcode;
  logic                    unused_funct7;

  assign opcode        = id_instruction[6:0];
  assign unused_funct7 = ^id_instruction[31:25];

  always_comb begin
    imm_src = 3'b000;
    case (opcode)
      OPC_STORE:         imm_src = 3'b001;
      OPC_BRANCH:        imm_src = 3'b010;
      OPC_LUI, OPC_AUIPC: imm_src = 3'b011;
      OPC_JAL:           imm_src = 3'b100;
      default:           imm_src = 3'b000;
    endcase
  end

  // Full 7-bit match also rejects any encoding with [1:0] != 2'b11.
  always_comb begin
    dec_ctrl        = '0;
    use_rs1         = 1'b0;
    use_rs2         = 1'b0;
    dec_ctrl.valid  = 1'b1;
    dec_ctrl.rd     = id_instruction[11:7];
    dec_ctrl.rs1    = id_instruction[19:15];
    dec_ctrl.rs2    = id_instruction[24:20];
    dec_ctrl.funct3 = id_instruction[14:12];
    case (opcode)
      OPC_OP: begin
        dec_ctrl.reg_write = 1'b1;
        use_rs1            = 1'b1;
        use_rs2            = 1'b1;
      end
      OPC_OPIMM: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        use_rs1            = 1'b1;
      end
      OPC_LOAD: begin
        dec_ctrl.reg_write  = 1'b1;
        dec_ctrl.mem_read   = 1'b1;
        dec_ctrl.alu_src    = 1'b1;
        dec_ctrl.result_src = 2'b01;
        use_rs1             = 1'b1;
      end
      OPC_STORE: begin
        dec_ctrl.mem_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        use_rs1            = 1'b1;
        use_rs2            = 1'b1;
      end
      OPC_BRANCH: begin
        dec_ctrl.branch = 1'b1;
        use_rs1         = 1'b1;
        use_rs2         = 1'b1;
      end
      OPC_JAL: begin
        dec_ctrl.jump       = 1'b1;
        dec_ctrl.reg_write  = 1'b1;
        dec_ctrl.result_src = 2'b10;
      end
      OPC_JALR: begin
        dec_ctrl.jump       = 1'b1;
        dec_ctrl.reg_write  = 1'b1;
        dec_ctrl.alu_src    = 1'b1;
        dec_ctrl.result_src = 2'b10;
        use_rs1             = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
      end
      default: dec_ctrl.illegal = 1'b1;
    endcase
    if (dec_ctrl.rd == 5'd0) begin
      dec_ctrl.reg_write = 1'b0;
    end
  end

  assign rs1_hit  = use_rs1 && (ex_q.rd == dec_ctrl.rs1);
  assign rs2_hit  = use_rs2 && (ex_q.rd == dec_ctrl.rs2);
  assign load_use = id_valid && ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) && (rs1_hit || rs2_hit);

  // A flush discards the ID instruction anyway, so it never needs to be held.
  assign stall_if = !rst && (mem_stall || (!ex_flush && load_use));
  assign stall_id = stall_if;

  always_comb begin
    ex_d         = ex_q;
    bubble_cnt_d = bubble_cnt_q;
    if (!mem_stall) begin
      if (ex_flush || load_use || !id_valid) begin
        ex_d = '0;
      end else begin
        ex_d = dec_ctrl;
      end
      if (!ex_flush && load_use && (bubble_cnt_q != '1)) begin
        bubble_cnt_d = bubble_cnt_q + BUBBLE_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q         <= '0;
      bubble_cnt_q <= '0;
    end else begin
      ex_q         <= ex_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ex_valid      = ex_q.valid;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_branch     = ex_q.branch;
  assign ex_jump       = ex_q.jump;
  assign ex_alu_src    = ex_q.alu_src;
  assign ex_illegal    = ex_q.illegal;
  assign ex_result_src = ex_q.result_src;
  assign ex_rd         = ex_q.rd;
  assign ex_rs1        = ex_q.rs1;
  assign ex_rs2        = ex_q.rs2;
  assign ex_funct3     = ex_q.funct3;
  assign bubble_count  = bubble_cnt_q;

endmodule
